// File: rtl/fp_wb_arb_pkg.sv
// -----------------------------------------------------------------------------
// fp_wb_arb_pkg
//   Shared definitions for the FP write-back arbiter:
//     - FLEN          : default width of the FP data paths
//     - FLAG_*        : bit positions of the IEEE exception flags (NV..NX)
//     - result record : field layout of one buffered FPU result {rd, data, flags}
//   No ports (package).
// -----------------------------------------------------------------------------
package fp_wb_arb_pkg;

   localparam int FLEN   = 32;

   // Register index and flag field widths.
   localparam int RD_W   = 5;
   localparam int FLAG_W = 5;

   // Exception flag bit positions inside a 5-bit flag vector.
   localparam int FLAG_NV = 4;   // invalid operation
   localparam int FLAG_DZ = 3;   // divide by zero
   localparam int FLAG_OF = 2;   // overflow
   localparam int FLAG_UF = 1;   // underflow
   localparam int FLAG_NX = 0;   // inexact

   // Result record at the default FLEN. Packed MSB..LSB as {rd, data, flags}.
   typedef struct packed {
      logic [RD_W-1:0]   rd;
      logic [FLEN-1:0]   data;
      logic [FLAG_W-1:0] flags;
   } fp_res_t;

   // Same layout for an arbitrary FLEN, expressed as flat bit offsets so the
   // FIFO can carry a plain vector whatever FLEN the top is built with.
   function automatic int res_w(input int flen);
      return RD_W + flen + FLAG_W;
   endfunction

   localparam int RES_FLAGS_LSB = 0;
   localparam int RES_DATA_LSB  = FLAG_W;

   function automatic int res_rd_lsb(input int flen);
      return FLAG_W + flen;
   endfunction

endpackage : fp_wb_arb_pkg

// File: rtl/fp_wb_arb_if.sv
// -----------------------------------------------------------------------------
// fp_wb_arb_if
//   Bundle of every non-clock signal of fp_wb_arb.
//   Ports of the arbiter (slave modport view):
//     FPU_Valid/FPU_Ready/FPU_Rd/FPU_Data/FPU_Flags : FPU result stream
//     Ld_Valid/Ld_Rd/Ld_Data                         : FLW load return
//     Busy_Set/Busy_Rd                               : issue-stage scoreboard set
//     Fflags_Clr                                     : CSR clear of fflags
//     Reg_Wr/Rd_Wr/Rd_In                             : register-file write port
//     Busy                                           : pending-write scoreboard
//     Fflags_Acc                                     : sticky exception flags
//
//   Handshake: the FPU stream is a valid/ready channel. A beat transfers on a
//   rising edge where FPU_Valid and FPU_Ready are both 1. FPU_Ready depends
//   only on buffer occupancy, never on FPU_Valid, so a producer may wait for
//   ready before raising valid without deadlock. Once FPU_Valid is raised the
//   producer keeps it and the payload stable until the beat transfers.
//   The load channel has no ready: every Ld_Valid cycle is consumed.
// -----------------------------------------------------------------------------
interface fp_wb_arb_if #(
   parameter int FLEN = fp_wb_arb_pkg::FLEN
);

   logic            FPU_Valid;
   logic            FPU_Ready;
   logic [4:0]      FPU_Rd;
   logic [FLEN-1:0] FPU_Data;
   logic [4:0]      FPU_Flags;

   logic            Ld_Valid;
   logic [4:0]      Ld_Rd;
   logic [FLEN-1:0] Ld_Data;

   logic            Busy_Set;
   logic [4:0]      Busy_Rd;
   logic            Fflags_Clr;

   logic            Reg_Wr;
   logic [4:0]      Rd_Wr;
   logic [FLEN-1:0] Rd_In;
   logic [31:0]     Busy;
   logic [4:0]      Fflags_Acc;

   // Producer side: FPU, load unit, issue stage and CSR logic.
   modport master (
      output FPU_Valid, FPU_Rd, FPU_Data, FPU_Flags,
      output Ld_Valid, Ld_Rd, Ld_Data,
      output Busy_Set, Busy_Rd, Fflags_Clr,
      input  FPU_Ready,
      input  Reg_Wr, Rd_Wr, Rd_In, Busy, Fflags_Acc
   );

   // Arbiter side.
   modport slave (
      input  FPU_Valid, FPU_Rd, FPU_Data, FPU_Flags,
      input  Ld_Valid, Ld_Rd, Ld_Data,
      input  Busy_Set, Busy_Rd, Fflags_Clr,
      output FPU_Ready,
      output Reg_Wr, Rd_Wr, Rd_In, Busy, Fflags_Acc
   );

endinterface : fp_wb_arb_if

// File: rtl/fp_res_fifo.sv
// -----------------------------------------------------------------------------
// fp_res_fifo
//   Small synchronous FIFO buffering FPU results ahead of write-back.
//   Ports:
//     clk_i    in   clock
//     rst_ni   in   asynchronous active-low reset (pointers and count only)
//     push_i   in   write request; ignored while full
//     din_i    in   entry to write
//     pop_i    in   read request; ignored while empty
//     dout_o   out  current head entry (valid while !empty_o)
//     full_o   out  occupancy == DEPTH
//     empty_o  out  occupancy == 0
//   DEPTH must be a power of two so the pointers wrap by natural overflow.
// -----------------------------------------------------------------------------
module fp_res_fifo #(
   parameter int W     = 42,
   parameter int DEPTH = 2
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         push_i,
   input  logic [W-1:0] din_i,
   input  logic         pop_i,
   output logic [W-1:0] dout_o,
   output logic         full_o,
   output logic         empty_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] cnt_q,    cnt_d;

   logic do_push;
   logic do_pop;

   assign full_o  = (cnt_q == CW'(DEPTH));
   assign empty_o = (cnt_q == '0);

   // Gating here keeps the count inside 0..DEPTH regardless of the caller.
   // When full, a push is refused even if a pop happens the same cycle; the
   // freed slot becomes visible through full_o on the next cycle.
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i  & ~empty_o;

   assign dout_o = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (do_push) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      unique case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage is not reset: an entry is only ever read after being written,
   // and clearing the pointers is enough to discard stale contents.
   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= din_i;
      end
   end

endmodule : fp_res_fifo

// File: rtl/fp_wb_arb.sv
// -----------------------------------------------------------------------------
// fp_wb_arb
//   Write-back arbiter for the F register file. Merges FLW load returns and
//   buffered FPU results onto one register-file write port, tracks pending
//   writes in a 32-bit scoreboard and accumulates sticky IEEE flags.
//   Ports:
//     CLK    in    clock, all state changes on the rising edge
//     rst_n  in    asynchronous active-low reset
//     bus    slave fp_wb_arb_if (see interface file for the signal list)
//   Priority: a load always wins the write port; the FPU FIFO drains only in
//   cycles with no load. Write-back outputs are registered, so a load shows
//   up one cycle after it is presented and an FPU result two cycles after its
//   transfer into an empty buffer.
// -----------------------------------------------------------------------------
module fp_wb_arb
   import fp_wb_arb_pkg::*;
#(
   parameter int FLEN  = fp_wb_arb_pkg::FLEN,
   parameter int DEPTH = 2
) (
   input  logic        CLK,
   input  logic        rst_n,
   fp_wb_arb_if.slave  bus
);

   localparam int W      = res_w(FLEN);
   localparam int RD_LSB = res_rd_lsb(FLEN);

   // ---------------------------------------------------------------- buffer
   logic [W-1:0]      push_entry;
   logic [W-1:0]      head_entry;
   logic              fifo_full;
   logic              fifo_empty;
   logic              pop;

   logic [RD_W-1:0]   head_rd;
   logic [FLEN-1:0]   head_data;
   logic [FLAG_W-1:0] head_flags;

   assign push_entry = {bus.FPU_Rd, bus.FPU_Data, bus.FPU_Flags};

   assign head_rd    = head_entry[RD_LSB +: RD_W];
   assign head_data  = head_entry[RES_DATA_LSB +: FLEN];
   assign head_flags = head_entry[RES_FLAGS_LSB +: FLAG_W];

   // A load takes the port outright; the FIFO head waits, unchanged, for a
   // load-free cycle.
   assign pop = ~bus.Ld_Valid & ~fifo_empty;

   assign bus.FPU_Ready = ~fifo_full;

   fp_res_fifo #(
      .W     (W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (CLK),
      .rst_ni  (rst_n),
      .push_i  (bus.FPU_Valid),
      .din_i   (push_entry),
      .pop_i   (pop),
      .dout_o  (head_entry),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // ------------------------------------------------------ write-back state
   logic              reg_wr_q,  reg_wr_d;
   logic [RD_W-1:0]   rd_wr_q,   rd_wr_d;
   logic [FLEN-1:0]   rd_in_q,   rd_in_d;
   logic [31:0]       busy_q,    busy_d;
   logic [FLAG_W-1:0] fflags_q,  fflags_d;

   always_comb begin
      // Index and data hold their last value when nothing is written.
      reg_wr_d = 1'b0;
      rd_wr_d  = rd_wr_q;
      rd_in_d  = rd_in_q;
      if (bus.Ld_Valid) begin
         reg_wr_d = 1'b1;
         rd_wr_d  = bus.Ld_Rd;
         rd_in_d  = bus.Ld_Data;
      end else if (pop) begin
         reg_wr_d = 1'b1;
         rd_wr_d  = head_rd;
         rd_in_d  = head_data;
      end
   end

   always_comb begin
      // The clear follows the registered write port, i.e. the write that is
      // being presented to the register file this cycle. The set is applied
      // last so a re-issue to the same register keeps the bit pending.
      busy_d = busy_q;
      if (reg_wr_q) begin
         busy_d[rd_wr_q] = 1'b0;
      end
      if (bus.Busy_Set) begin
         busy_d[bus.Busy_Rd] = 1'b1;
      end
   end

   always_comb begin
      // A CSR clear drops history, but flags of a result retiring in the same
      // cycle are still recorded. Loads raise no exceptions.
      fflags_d = bus.Fflags_Clr ? '0 : fflags_q;
      if (pop) begin
         fflags_d = fflags_d | head_flags;
      end
   end

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         reg_wr_q <= 1'b0;
         rd_wr_q  <= '0;
         rd_in_q  <= '0;
         busy_q   <= '0;
         fflags_q <= '0;
      end else begin
         reg_wr_q <= reg_wr_d;
         rd_wr_q  <= rd_wr_d;
         rd_in_q  <= rd_in_d;
         busy_q   <= busy_d;
         fflags_q <= fflags_d;
      end
   end

   assign bus.Reg_Wr     = reg_wr_q;
   assign bus.Rd_Wr      = rd_wr_q;
   assign bus.Rd_In      = rd_in_q;
   assign bus.Busy       = busy_q;
   assign bus.Fflags_Acc = fflags_q;

endmodule : fp_wb_arb

// File: tb/tb_fp_wb_arb.sv
// -----------------------------------------------------------------------------
// tb_fp_wb_arb
//   Directed self-checking bench for fp_wb_arb (FLEN=32, DEPTH=2).
//   Inputs change 1 time unit after a rising edge; outputs are read there too.
// -----------------------------------------------------------------------------
module tb_fp_wb_arb;

   localparam int FLEN = 32;

   logic CLK;
   logic rst_n;

   int n_checks = 0;
   int n_fail   = 0;

   // Expected FPU write-backs, {rd, data}, in order.
   logic [36:0] exp_q[$];

   fp_wb_arb_if #(.FLEN(FLEN)) bus ();

   fp_wb_arb #(
      .FLEN  (FLEN),
      .DEPTH (2)
   ) dut (
      .CLK   (CLK),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // ----------------------------------------------------- clock and reset
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // -------------------------------------------------------- driver tasks
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic set_ld(input logic v, input logic [4:0] rd, input logic [31:0] d);
      bus.Ld_Valid = v;
      bus.Ld_Rd    = rd;
      bus.Ld_Data  = d;
   endtask

   task automatic set_fpu(input logic v, input logic [4:0] rd, input logic [31:0] d,
                          input logic [4:0] fl);
      bus.FPU_Valid = v;
      bus.FPU_Rd    = rd;
      bus.FPU_Data  = d;
      bus.FPU_Flags = fl;
   endtask

   task automatic set_busy(input logic v, input logic [4:0] rd);
      bus.Busy_Set = v;
      bus.Busy_Rd  = rd;
   endtask

   task automatic drive_idle();
      set_ld(1'b0, 5'd0, 32'h0);
      set_fpu(1'b0, 5'd0, 32'h0, 5'd0);
      set_busy(1'b0, 5'd0);
      bus.Fflags_Clr = 1'b0;
   endtask

   // ----------------------------------------------------------- checking
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ------------------------------------------------------------ stimulus
   initial begin
      logic [36:0] e;
      int          nwr;

      rst_n = 1'b0;
      drive_idle();
      #3;
      chk("rst_reg_wr", bus.Reg_Wr, 0);
      chk("rst_rd_wr",  bus.Rd_Wr, 0);
      chk("rst_rd_in",  bus.Rd_In, 0);
      chk("rst_busy",   bus.Busy, 0);
      chk("rst_fflags", bus.Fflags_Acc, 0);
      chk("rst_ready",  bus.FPU_Ready, 1);
      @(posedge CLK);
      #1;
      rst_n = 1'b1;

      // Load only: one-cycle latency, then index/data hold with Reg_Wr low.
      set_ld(1'b1, 5'd3, 32'h3F800000);
      tick();
      set_ld(1'b0, 5'd0, 32'h0);
      chk("ld_reg_wr", bus.Reg_Wr, 1);
      chk("ld_rd_wr",  bus.Rd_Wr, 3);
      chk("ld_rd_in",  bus.Rd_In, 32'h3F800000);
      tick();
      chk("ld_idle_reg_wr", bus.Reg_Wr, 0);
      chk("ld_idle_rd_hold", bus.Rd_Wr, 3);
      chk("ld_idle_data_hold", bus.Rd_In, 32'h3F800000);

      // Conflict: load rd7 wins at N+1, FPU rd5 follows at N+2.
      set_ld(1'b1, 5'd7, 32'hC0000000);
      set_fpu(1'b1, 5'd5, 32'h40000000, 5'd0);
      chk("cf_ready", bus.FPU_Ready, 1);
      tick();
      drive_idle();
      chk("cf_n1_wr", bus.Reg_Wr, 1);
      chk("cf_n1_rd", bus.Rd_Wr, 7);
      chk("cf_n1_data", bus.Rd_In, 32'hC0000000);
      tick();
      chk("cf_n2_wr", bus.Reg_Wr, 1);
      chk("cf_n2_rd", bus.Rd_Wr, 5);
      chk("cf_n2_data", bus.Rd_In, 32'h40000000);
      tick();
      chk("cf_n3_wr", bus.Reg_Wr, 0);

      // FPU only into empty buffer, destination F0: write at N+2.
      set_fpu(1'b1, 5'd0, 32'h12345678, 5'd0);
      tick();
      drive_idle();
      chk("fp_n1_wr", bus.Reg_Wr, 0);
      tick();
      chk("fp_n2_wr", bus.Reg_Wr, 1);
      chk("fp_n2_rd0", bus.Rd_Wr, 0);
      chk("fp_n2_data", bus.Rd_In, 32'h12345678);

      // Backpressure: loads for 6 cycles while the FPU offers A, B, C.
      exp_q = {};
      exp_q.push_back({5'd20, 32'hAAAA0001});
      exp_q.push_back({5'd21, 32'hAAAA0002});
      exp_q.push_back({5'd22, 32'hAAAA0003});
      for (int i = 0; i < 6; i++) begin
         set_ld(1'b1, 5'(10 + i), 32'(i));
         if (i == 0)      set_fpu(1'b1, 5'd20, 32'hAAAA0001, 5'd0);
         else if (i == 1) set_fpu(1'b1, 5'd21, 32'hAAAA0002, 5'd0);
         else             set_fpu(1'b1, 5'd22, 32'hAAAA0003, 5'd0);
         chk($sformatf("bp_ready_%0d", i), bus.FPU_Ready, (i < 2) ? 1 : 0);
         tick();
         chk($sformatf("bp_ld_wr_%0d", i), bus.Reg_Wr, 1);
         chk($sformatf("bp_ld_rd_%0d", i), bus.Rd_Wr, 10 + i);
         chk($sformatf("bp_ld_data_%0d", i), bus.Rd_In, i);
      end
      set_ld(1'b0, 5'd0, 32'h0);
      nwr = 0;
      for (int c = 0; c < 8; c++) begin
         if (c == 0) chk("bp_full_pop_ready", bus.FPU_Ready, 0);
         if (c == 1) chk("bp_slot_freed", bus.FPU_Ready, 1);
         tick();
         if (c == 1) set_fpu(1'b0, 5'd0, 32'h0, 5'd0);
         if (bus.Reg_Wr) begin
            nwr++;
            if (exp_q.size() == 0) begin
               chk("bp_extra_write", nwr, 3);
            end else begin
               e = exp_q.pop_front();
               chk($sformatf("bp_drain_rd_%0d", nwr), bus.Rd_Wr, e[36:32]);
               chk($sformatf("bp_drain_data_%0d", nwr), bus.Rd_In, e[31:0]);
            end
         end
      end
      chk("bp_write_count", nwr, 3);
      chk("bp_queue_left", exp_q.size(), 0);

      // Scoreboard set, clear, and set-wins-over-clear.
      set_busy(1'b1, 5'd9);
      tick();
      set_busy(1'b0, 5'd0);
      chk("sb_set", bus.Busy, 32'h0000_0200);
      set_ld(1'b1, 5'd9, 32'h9);
      tick();
      set_ld(1'b0, 5'd0, 32'h0);
      chk("sb_wr_rd9", bus.Rd_Wr, 9);
      chk("sb_still_busy", bus.Busy, 32'h0000_0200);
      tick();
      chk("sb_cleared", bus.Busy, 32'h0);
      set_busy(1'b1, 5'd9);
      tick();
      set_busy(1'b0, 5'd0);
      set_ld(1'b1, 5'd9, 32'h19);
      tick();
      set_ld(1'b0, 5'd0, 32'h0);
      set_busy(1'b1, 5'd9);
      chk("sb_same_wr", bus.Reg_Wr, 1);
      tick();
      set_busy(1'b0, 5'd0);
      chk("sb_set_wins", bus.Busy, 32'h0000_0200);

      // Flag accumulation and clear-with-pop.
      set_fpu(1'b1, 5'd1, 32'h1, 5'b00001);
      tick();
      set_fpu(1'b1, 5'd2, 32'h2, 5'b10000);
      tick();
      set_fpu(1'b0, 5'd0, 32'h0, 5'd0);
      chk("fl_first", bus.Fflags_Acc, 5'b00001);
      tick();
      chk("fl_or", bus.Fflags_Acc, 5'b10001);
      set_fpu(1'b1, 5'd3, 32'h3, 5'b00100);
      tick();
      set_fpu(1'b0, 5'd0, 32'h0, 5'd0);
      bus.Fflags_Clr = 1'b1;
      tick();
      bus.Fflags_Clr = 1'b0;
      chk("fl_clr_pop", bus.Fflags_Acc, 5'b00100);

      // Reset mid-run with two buffered results behind a stream of loads.
      set_ld(1'b1, 5'd11, 32'hB);
      set_fpu(1'b1, 5'd4, 32'hE1, 5'b00010);
      tick();
      set_fpu(1'b1, 5'd6, 32'hE2, 5'd0);
      tick();
      set_fpu(1'b0, 5'd0, 32'h0, 5'd0);
      chk("mr_full", bus.FPU_Ready, 0);
      chk("mr_pre_wr", bus.Reg_Wr, 1);
      #2;
      rst_n = 1'b0;
      set_ld(1'b0, 5'd0, 32'h0);
      #1;
      chk("mr_reg_wr", bus.Reg_Wr, 0);
      chk("mr_rd_wr",  bus.Rd_Wr, 0);
      chk("mr_rd_in",  bus.Rd_In, 0);
      chk("mr_busy",   bus.Busy, 0);
      chk("mr_fflags", bus.Fflags_Acc, 0);
      chk("mr_ready",  bus.FPU_Ready, 1);
      tick();
      rst_n = 1'b1;
      nwr = 0;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (bus.Reg_Wr) nwr++;
      end
      chk("mr_no_write", nwr, 0);
      chk("mr_ready_after", bus.FPU_Ready, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_fp_wb_arb
